// File: rtl/rca32_multiword_ctrl.sv
// -----------------------------------------------------------------------------
// rca32_multiword_ctrl
//
// Wide (32*WORDS-bit) adder/subtractor built from one 32-bit ripple-carry
// adder that is reused once per word, least-significant word first. The
// carry between words lives in a register, so the combinational depth is
// one 32-bit ripple no matter how wide the operands are.
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   rst_n        - asynchronous active-low reset
//   start_valid  - command valid
//   start_ready  - command ready (high only while idle)
//   a, b         - W-bit operands, captured when a command is accepted
//   cin          - carry-in for add (ignored for subtract)
//   op_sub       - 0: a + b + cin, 1: a - b
//   res_valid    - result valid; held until res_ready
//   res_ready    - result consumer ready
//   sum          - W-bit registered result
//   cout         - carry out of the MSB (subtract: 1 means no borrow)
//   overflow     - two's-complement signed overflow of the W-bit result
//   busy         - high while an operation is running or waiting to be taken
//
// Also contains g_rca32, the shared 32-bit ripple-carry adder.
// -----------------------------------------------------------------------------

// 32-bit ripple-carry adder: a plain chain of full adders.
module g_rca32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    logic [32:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar g = 0; g < 32; g++) begin : gen_fa
        assign o_sum[g]     = i_a[g] ^ i_b[g] ^ w_carry[g];
        assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_carry[32];

endmodule

module rca32_multiword_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    input  logic                  cin,
    input  logic                  op_sub,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  overflow,
    output logic                  busy
);

    localparam int W    = 32 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [W-1:0]    r_aReg;
    logic [W-1:0]    r_bReg;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic            r_overflow;
    logic [IDXW-1:0] r_idx;

    logic [31:0] w_wordA;
    logic [31:0] w_wordB;
    logic [31:0] w_addSum;
    logic        w_addCout;
    logic        w_accept;
    logic        w_lastWord;

    // Current word of each operand; r_idx never exceeds WORDS-1.
    assign w_wordA    = r_aReg[32*r_idx +: 32];
    assign w_wordB    = r_bReg[32*r_idx +: 32];
    assign w_accept   = start_valid && (r_state == IDLE);
    assign w_lastWord = (r_idx == LAST_IDX);

    g_rca32 u_rca (
        .i_a    (w_wordA),
        .i_b    (w_wordB),
        .i_cin  (r_carry),
        .o_sum  (w_addSum),
        .o_cout (w_addCout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and handshake outputs; handshake outputs decode state only.
    always_comb begin
        w_nextState = r_state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_lastWord) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath. Subtraction is done as a + ~b + 1, so b is stored inverted
    // and the carry starts at 1. cout and overflow have their own registers
    // because the carry register and operands are reloaded on the next
    // accept, while the reported result must persist until the next one
    // completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aReg     <= '0;
            r_bReg     <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_idx      <= '0;
        end else begin
            if (w_accept) begin
                r_aReg  <= a;
                r_bReg  <= op_sub ? ~b : b;
                r_carry <= op_sub ? 1'b1 : cin;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                r_sum[32*r_idx +: 32] <= w_addSum;
                r_carry               <= w_addCout;
                if (w_lastWord) begin
                    r_cout     <= w_addCout;
                    r_overflow <= (r_aReg[W-1] == r_bReg[W-1]) &&
                                  (w_addSum[31] != r_aReg[W-1]);
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_rca32_multiword_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rca32_multiword_ctrl
//
// Directed self-checking bench for rca32_multiword_ctrl with WORDS=4.
// Each task drives one scenario and checks its own expected values.
// -----------------------------------------------------------------------------
module tb_rca32_multiword_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;
    localparam int LAT   = WORDS;

    logic          clk;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          op_sub;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          overflow;
    logic          busy;

    int checks;
    int errors;

    rca32_multiword_ctrl #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .op_sub      (op_sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one command, let it be accepted, then wait (bounded) for
    // res_valid. lat is the number of cycles after the accept edge, or -1
    // if the result never showed up.
    task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub, output int lat);
        a           = ta;
        b           = tb;
        cin         = tcin;
        op_sub      = tsub;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (res_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, res_valid, busy, cout, overflow} !== 5'b10000 || sum !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h, required 1 0 0 0 0 sum=0",
                     start_ready, res_valid, busy, cout, overflow, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_carry_chain();
        int lat;
        runOp({W{1'b1}}, '0, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("[TB] FAIL carry_latency: got %0d required %0d", lat, LAT);
        end
        checks++;
        if (sum !== '0 || cout !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL carry_result: sum=%h cout=%b ovf=%b, required sum=0 cout=1 ovf=0",
                     sum, cout, overflow);
        end
        consume();
        checks++;
        if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL carry_handshake: vld=%b rdy=%b busy=%b, required 0 1 0",
                     res_valid, start_ready, busy);
        end
    endtask

    task automatic test_subtract();
        int lat;
        runOp(128'd5, 128'd7, 1'b1, 1'b1, lat);
        checks++;
        if (lat !== LAT || sum !== {{(W-1){1'b1}}, 1'b0} || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_5_minus_7: lat=%0d sum=%h cout=%b ovf=%b, required lat=4 sum=fff..fe cout=0 ovf=0",
                     lat, sum, cout, overflow);
        end
        consume();
        runOp(128'd7, 128'd5, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== LAT || sum !== 128'd2 || cout !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_7_minus_5: lat=%0d sum=%h cout=%b ovf=%b, required lat=4 sum=2 cout=1 ovf=0",
                     lat, sum, cout, overflow);
        end
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        runOp({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== LAT || sum !== {1'b1, {(W-1){1'b0}}} || overflow !== 1'b1 || cout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_add: lat=%0d sum=%h cout=%b ovf=%b, required sum=800..0 cout=0 ovf=1",
                     lat, sum, cout, overflow);
        end
        consume();
        runOp({1'b1, {(W-1){1'b0}}}, 128'd1, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== LAT || sum !== {1'b0, {(W-1){1'b1}}} || overflow !== 1'b1 || cout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sub: lat=%0d sum=%h cout=%b ovf=%b, required sum=7ff..f cout=1 ovf=1",
                     lat, sum, cout, overflow);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int badCycles;
        logic [W-1:0] firstSum;
        firstSum = 128'h0000_0001_0000_0000_ffff_ffff_0000_0003;
        runOp(128'h0000_0000_ffff_ffff_ffff_ffff_0000_0001,
              128'h0000_0000_0000_0001_0000_0000_0000_0002, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== LAT || sum !== firstSum || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_first: lat=%0d sum=%h cout=%b ovf=%b, required sum=%h cout=0 ovf=0",
                     lat, sum, cout, overflow, firstSum);
        end
        a           = 128'd10;
        b           = 128'd20;
        cin         = 1'b0;
        op_sub      = 1'b0;
        res_ready   = 1'b0;
        start_valid = 1'b1;
        badCycles   = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b1 ||
                sum !== firstSum || cout !== 1'b0 || overflow !== 1'b0) begin
                badCycles++;
            end
        end
        checks++;
        if (badCycles !== 0) begin
            errors++;
            $display("[TB] FAIL bp_hold: %0d unstable cycles, required 0", badCycles);
        end
        consume();
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || sum !== firstSum) begin
            errors++;
            $display("[TB] FAIL bp_release: rdy=%b vld=%b sum=%h, required rdy=1 vld=0 sum=%h",
                     start_ready, res_valid, sum, firstSum);
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || start_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_next_accept: busy=%b rdy=%b, required busy=1 rdy=0", busy, start_ready);
        end
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (res_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat !== LAT || sum !== 128'd30 || cout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_next_result: lat=%0d sum=%h cout=%b, required lat=4 sum=30 cout=0",
                     lat, sum, cout);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        a           = {W{1'b1}};
        b           = {W{1'b1}};
        cin         = 1'b1;
        op_sub      = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (sum[63:0] !== 64'hffff_ffff_ffff_ffff || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrun_progress: low words=%h busy=%b, required ffffffffffffffff busy=1",
                     sum[63:0], busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_ready, res_valid, busy, cout, overflow} !== 5'b10000 || sum !== '0) begin
            errors++;
            $display("[TB] FAIL midrun_reset: rdy=%b vld=%b busy=%b cout=%b ovf=%b sum=%h, required 1 0 0 0 0 sum=0",
                     start_ready, res_valid, busy, cout, overflow, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        runOp(128'h1_0000_0000, 128'hFFFF_FFFF, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== LAT || sum !== 128'h1_FFFF_FFFF || cout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_op: lat=%0d sum=%h cout=%b ovf=%b, required sum=1ffffffff cout=0 ovf=0",
                     lat, sum, cout, overflow);
        end
        consume();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        op_sub      = 1'b0;
        #2;
        test_reset();
        test_carry_chain();
        test_subtract();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
